// File: rtl/alsu_arbiter_if.sv
// Bundle between the ALSU arbiter and its surroundings: two command requesters,
// the shared ALSU pins, and the response channel.
// Latency: none (wires only). Backpressure: valid/ready on both request and response sides.
// Ports: slave = arbiter view, master = requester/ALSU/consumer view.
interface alsu_arbiter_if;
    // requester side, cmd = {bypass_B, bypass_A, red_op_B, red_op_A, direction, serial_in, cin, opcode, B, A}
    logic        req0_valid;
    logic        req0_ready;
    logic [15:0] req0_cmd;
    logic        req1_valid;
    logic        req1_ready;
    logic [15:0] req1_cmd;

    // shared ALSU pins
    logic [2:0]  alsu_A;
    logic [2:0]  alsu_B;
    logic [2:0]  alsu_opcode;
    logic        alsu_cin;
    logic        alsu_serial_in;
    logic        alsu_direction;
    logic        alsu_red_op_A;
    logic        alsu_red_op_B;
    logic        alsu_bypass_A;
    logic        alsu_bypass_B;
    logic [5:0]  alsu_out;

    // response side
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [5:0]  rsp_data;
    logic        rsp_err;

    logic        busy;

    modport slave (
        input  req0_valid, req0_cmd, req1_valid, req1_cmd, alsu_out, rsp_ready,
        output req0_ready, req1_ready,
        output alsu_A, alsu_B, alsu_opcode, alsu_cin, alsu_serial_in, alsu_direction,
        output alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B,
        output rsp_valid, rsp_id, rsp_data, rsp_err, busy
    );

    modport master (
        output req0_valid, req0_cmd, req1_valid, req1_cmd, alsu_out, rsp_ready,
        input  req0_ready, req1_ready,
        input  alsu_A, alsu_B, alsu_opcode, alsu_cin, alsu_serial_in, alsu_direction,
        input  alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B,
        input  rsp_valid, rsp_id, rsp_data, rsp_err, busy
    );
endinterface

// File: rtl/alsu_arbiter.sv
// Round-robin arbiter sharing one ALSU between two requesters; opcodes 6/7 rejected locally.
// Latency: accept T -> rsp_valid T+LATENCY+2 (error path T+1); one command in flight.
// Backpressure: requesters see ready only in IDLE; response held until rsp_valid & rsp_ready.
// Ports: clk, rst (async active-high), bus (alsu_arbiter_if.slave: req0/req1, alsu pins, rsp, busy).
module alsu_arbiter #(
    parameter int LATENCY = 2
) (
    input logic           clk,
    input logic           rst,
    alsu_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam logic [2:0] LAST_WAIT = 3'(LATENCY - 1);

    logic [1:0]  state;
    logic        last_grant;
    logic [2:0]  wait_cnt;
    logic [15:0] pins;          // latched command, visible on the ALSU pins only in ISSUE
    logic        rsp_valid_q;
    logic        rsp_id_q;
    logic        rsp_err_q;
    logic [5:0]  rsp_data_q;

    logic        grant;
    logic        accept;
    logic [15:0] sel_cmd;
    logic        illegal;

    // On a tie the requester not served last time wins; otherwise whoever is valid.
    always_comb begin
        grant   = (bus.req0_valid && bus.req1_valid) ? ~last_grant : bus.req1_valid;
        accept  = (state == IDLE) && (bus.req0_valid || bus.req1_valid);
        sel_cmd = grant ? bus.req1_cmd : bus.req0_cmd;
        illegal = (sel_cmd[8:6] >= 3'd6);
    end

    assign bus.req0_ready = !rst && (state == IDLE) && bus.req0_valid && !grant;
    assign bus.req1_ready = !rst && (state == IDLE) && bus.req1_valid && grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            wait_cnt    <= 3'd0;
            pins        <= 16'd0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= 6'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        last_grant <= grant;
                        rsp_id_q   <= grant;
                        if (illegal) begin
                            // never touches the ALSU; answer straight away
                            rsp_err_q   <= 1'b1;
                            rsp_data_q  <= 6'd0;
                            rsp_valid_q <= 1'b1;
                            state       <= RESP;
                        end else begin
                            pins  <= sel_cmd;
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    pins     <= 16'd0;
                    wait_cnt <= 3'd0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == LAST_WAIT) begin
                        rsp_data_q  <= bus.alsu_out;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state       <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.alsu_A         = pins[2:0];
    assign bus.alsu_B         = pins[5:3];
    assign bus.alsu_opcode    = pins[8:6];
    assign bus.alsu_cin       = pins[9];
    assign bus.alsu_serial_in = pins[10];
    assign bus.alsu_direction = pins[11];
    assign bus.alsu_red_op_A  = pins[12];
    assign bus.alsu_red_op_B  = pins[13];
    assign bus.alsu_bypass_A  = pins[14];
    assign bus.alsu_bypass_B  = pins[15];

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_alsu_arbiter.sv
// Bench for alsu_arbiter: behavioural ALSU on the pins, transaction-level model,
// per-cycle compare at negedge plus hand-computed directed checks.
module tb_alsu_arbiter;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alsu_arbiter_if bus ();
    alsu_arbiter #(.LATENCY(LAT)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ALSU function; prev is the ALSU's own output register (shift/rotate source)
    function automatic logic [5:0] alsu_f(input logic [15:0] c, input logic [5:0] prev);
        logic [2:0] a, b;
        a = c[2:0];
        b = c[5:3];
        if (c[14]) return {3'b0, a};
        if (c[15]) return {3'b0, b};
        case (c[8:6])
            3'd0: return c[12] ? {5'b0, &a} : c[13] ? {5'b0, &b} : {3'b0, a & b};
            3'd1: return c[12] ? {5'b0, ^a} : c[13] ? {5'b0, ^b} : {3'b0, a ^ b};
            3'd2: return 6'(a) + 6'(b) + 6'(c[9]);
            3'd3: return 6'(a) * 6'(b);
            3'd4: return c[11] ? {prev[4:0], c[10]} : {c[10], prev[5:1]};
            3'd5: return c[11] ? {prev[4:0], prev[5]} : {prev[0], prev[5:1]};
            default: return 6'd0;
        endcase
    endfunction

    function automatic logic [15:0] dut_pins();
        return {bus.alsu_bypass_B, bus.alsu_bypass_A, bus.alsu_red_op_B, bus.alsu_red_op_A,
                bus.alsu_direction, bus.alsu_serial_in, bus.alsu_cin,
                bus.alsu_opcode, bus.alsu_B, bus.alsu_A};
    endfunction

    // behavioural ALSU: result appears on alsu_out LAT edges after the pins are presented
    logic [5:0] pipe [LAT];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) pipe[i] <= 6'd0;
        end else begin
            pipe[0] <= alsu_f(dut_pins(), pipe[LAT-1]);
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign bus.alsu_out = pipe[LAT-1];

    // transaction-level model, compared every cycle at negedge
    bit          m_busy = 1'b0;
    bit          m_ptr  = 1'b1;
    int          m_acc  = 0;
    logic [15:0] m_cmd  = 16'd0;
    bit          m_id   = 1'b0;
    int          hs_count = 0;
    int          rv_cycles = 0;
    int          rsp_log [$];

    always @(negedge clk) begin
        bit m_illegal, exp_v, g, exp_r0, exp_r1;
        int since;
        if (rst) begin
            m_busy = 1'b0;
            m_ptr  = 1'b1;
            chk("rst_req0_ready", int'(bus.req0_ready), 0);
            chk("rst_req1_ready", int'(bus.req1_ready), 0);
            chk("rst_busy", int'(bus.busy), 0);
            chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
            chk("rst_rsp_id", int'(bus.rsp_id), 0);
            chk("rst_rsp_data", int'(bus.rsp_data), 0);
            chk("rst_rsp_err", int'(bus.rsp_err), 0);
            chk("rst_pins", int'(dut_pins()), 0);
        end else begin
            m_illegal = (m_cmd[8:6] >= 3'd6);
            since     = cyc - m_acc;
            exp_v     = m_busy && (since >= (m_illegal ? 1 : LAT + 2));
            g         = (bus.req0_valid && bus.req1_valid) ? !m_ptr : bus.req1_valid;
            exp_r0    = !m_busy && bus.req0_valid && !g;
            exp_r1    = !m_busy && bus.req1_valid && g;
            chk("req0_ready", int'(bus.req0_ready), int'(exp_r0));
            chk("req1_ready", int'(bus.req1_ready), int'(exp_r1));
            chk("busy", int'(bus.busy), int'(m_busy));
            chk("rsp_valid", int'(bus.rsp_valid), int'(exp_v));
            chk("alsu_pins", int'(dut_pins()),
                (m_busy && !m_illegal && since == 1) ? int'(m_cmd) : 0);
            if (exp_v) begin
                chk("rsp_id", int'(bus.rsp_id), int'(m_id));
                chk("rsp_err", int'(bus.rsp_err), int'(m_illegal));
                chk("rsp_data", int'(bus.rsp_data),
                    m_illegal ? 0 : int'(alsu_f(m_cmd, 6'd0)));
            end
            if (bus.rsp_valid) rv_cycles++;
            if (bus.rsp_valid && bus.rsp_ready) begin
                hs_count++;
                rsp_log.push_back(int'(bus.rsp_id));
            end
            // advance the model across the coming edge
            if (m_busy) begin
                if (exp_v && bus.rsp_ready) m_busy = 1'b0;
            end else if (bus.req0_valid || bus.req1_valid) begin
                m_busy = 1'b1;
                m_ptr  = g;
                m_id   = g;
                m_cmd  = g ? bus.req1_cmd : bus.req0_cmd;
                m_acc  = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // present one command in an IDLE cycle; n = cycles until rsp_valid (-1 on timeout)
    task automatic issue(input int who, input logic [15:0] c, output int n, output logic [15:0] pins_t1);
        n = -1;
        pins_t1 = 16'd0;
        if (who == 0) begin bus.req0_cmd = c; bus.req0_valid = 1'b1; end
        else          begin bus.req1_cmd = c; bus.req1_valid = 1'b1; end
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (k == 1) begin
                bus.req0_valid = 1'b0;
                bus.req1_valid = 1'b0;
                pins_t1 = dut_pins();
            end
            if (bus.rsp_valid) begin
                n = k;
                break;
            end
        end
    endtask

    function automatic logic [15:0] rr_cmd(input int who, input int i);
        return 16'h0080 | 16'((who + 1) << 3) | 16'(i);   // add: A=i, B=who+1
    endfunction

    initial begin
        int n, hs0, i0, i1, rv0;
        bit a0, a1;
        logic [15:0] p1;

        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_cmd   = 16'd0;
        bus.req1_cmd   = 16'd0;
        bus.rsp_ready  = 1'b1;

        // reset: ready must stay low even with a valid request
        repeat (2) tick();
        bus.req0_valid = 1'b1;
        #1;
        chk("reset_req0_ready_lit", int'(bus.req0_ready), 0);
        chk("reset_busy_lit", int'(bus.busy), 0);
        bus.req0_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // round-robin: both requesters hold valid, four commands each
        rsp_log.delete();
        i0 = 0;
        i1 = 0;
        bus.req0_cmd   = rr_cmd(0, 0);
        bus.req1_cmd   = rr_cmd(1, 0);
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        for (int k = 0; k < 200 && rsp_log.size() < 8; k++) begin
            @(negedge clk);
            a0 = bus.req0_valid && bus.req0_ready;
            a1 = bus.req1_valid && bus.req1_ready;
            tick();
            if (a0) begin
                i0++;
                if (i0 == 4) bus.req0_valid = 1'b0; else bus.req0_cmd = rr_cmd(0, i0);
            end
            if (a1) begin
                i1++;
                if (i1 == 4) bus.req1_valid = 1'b0; else bus.req1_cmd = rr_cmd(1, i1);
            end
        end
        chk("rr_count", rsp_log.size(), 8);
        for (int k = 0; k < 8 && k < rsp_log.size(); k++) chk("rr_id_order", rsp_log[k], k % 2);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        tick();

        // single op: AND of 101 and 110
        issue(0, 16'h0035, n, p1);
        chk("single_pins_t1", int'(p1), 16'h0035);
        chk("single_latency", n, LAT + 2);
        chk("single_data", int'(bus.rsp_data), 6'b000100);
        chk("single_id", int'(bus.rsp_id), 0);
        chk("single_err", int'(bus.rsp_err), 0);
        tick();

        // illegal opcode 7 from requester 1
        issue(1, 16'h01C5, n, p1);
        chk("illegal_opcode_t1", int'(p1[8:6]), 0);
        chk("illegal_latency", n, 1);
        chk("illegal_err", int'(bus.rsp_err), 1);
        chk("illegal_data", int'(bus.rsp_data), 0);
        chk("illegal_id", int'(bus.rsp_id), 1);
        tick();

        // shift left from the idle-pattern output with serial_in=1
        issue(0, 16'h0D00, n, p1);
        chk("shift_latency", n, LAT + 2);
        chk("shift_data", int'(bus.rsp_data), 6'b000001);
        tick();

        // backpressure: XOR 011^101 = 110 held for 5 cycles
        bus.rsp_ready = 1'b0;
        issue(0, 16'h006B, n, p1);
        chk("bp_latency", n, LAT + 2);
        hs0 = hs_count;
        bus.req0_cmd   = 16'h0035;
        bus.req1_cmd   = 16'h0035;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("bp_data", int'(bus.rsp_data), 6'b000110);
            chk("bp_valid", int'(bus.rsp_valid), 1);
            chk("bp_req0_ready", int'(bus.req0_ready), 0);
            chk("bp_req1_ready", int'(bus.req1_ready), 0);
            chk("bp_busy", int'(bus.busy), 1);
            tick();
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rsp_ready  = 1'b1;
        tick();
        chk("bp_released_valid", int'(bus.rsp_valid), 0);
        tick();
        chk("bp_one_handshake", hs_count - hs0, 1);

        // reset in the middle of WAIT drops the command
        bus.req0_cmd   = 16'h00D3;
        bus.req0_valid = 1'b1;
        tick();
        bus.req0_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("midrst_busy", int'(bus.busy), 0);
        chk("midrst_pins", int'(dut_pins()), 0);
        tick();
        rst = 1'b0;
        rv0 = rv_cycles;
        repeat (6) tick();
        chk("midrst_no_rsp", rv_cycles - rv0, 0);
        issue(0, 16'h00D3, n, p1);
        chk("after_rst_latency", n, LAT + 2);
        chk("after_rst_data", int'(bus.rsp_data), 6);
        tick();
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end
endmodule
